jk_bank_arbiter: RTL and testbench

//   Shares a bank of NBITS JK flip-flops between NREQ requesters. Each requester issues
//   one JK command (hold/reset/set/toggle) against one bit index. A round-robin arbiter

---
 rtl/jk_bank_arbiter_pkg.sv | 33 +++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_bank_arbiter.sv | 121 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// jk_bank_arbiter_pkg
//   Shared definitions for the JK flip-flop bank arbiter:
//     - jk_op_e : {j,k} command encoding (hold / reset / set / toggle)
//     - CNT_W   : width of the executed-command counter
//     - jk_next : next-state function of a single JK flip-flop
// ----------------------------------------------------------------------------
package jk_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  localparam int CNT_W = 16;

  // Classic JK characteristic equation expressed as a command decode.
  function automatic logic jk_next(input logic cur, input logic j, input logic k);
    logic nxt;
    nxt = cur;
    case (jk_op_e'({j, k}))
      JK_HOLD: nxt = cur;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// ----------------------------------------------------------------------------
// jk_cell
//   One JK flip-flop of the shared bank.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   asynchronous reset, active-high, clears q
//     en   in   cell selected this cycle; when low the cell holds
//     j    in   J input (only meaningful while en is high)
//     k    in   K input (only meaningful while en is high)
//     q    out  flip-flop state
// ----------------------------------------------------------------------------
module jk_cell
  import jk_bank_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// ----------------------------------------------------------------------------
// jk_bank_arbiter
//   Shares a bank of NBITS JK flip-flops between NREQ requesters. Each cycle a
//   round-robin search picks at most one eligible requester, applies its {j,k}
//   command to the addressed bit on the same edge, and acknowledges it with a
//   one-cycle one-hot grant in the following cycle.
//   Parameters:
//     NREQ   number of requesters (2..8)
//     NBITS  number of flip-flops in the bank (1..32)
//     IDXW   bit-index width, 2**IDXW >= NBITS
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous reset, active-high
//     req      in   per-requester command valid
//     op       in   {j,k} per requester, slice r = op[2r+1:2r]
//     idx      in   target bit per requester, slice r = idx[IDXW*r +: IDXW]
//     gnt      out  one-hot acknowledge, high one cycle per executed command
//     q        out  flip-flop bank outputs
//     cmd_cnt  out  executed-command count, wraps silently
// ----------------------------------------------------------------------------
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic [CNT_W-1:0]     cmd_cnt
);

  localparam int PTRW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0]  ptr;
  logic [NREQ-1:0]  elig;
  logic             win_found;
  logic [PTRW-1:0]  win;
  logic [1:0]       win_op;
  logic [IDXW-1:0]  win_idx;
  logic [NBITS-1:0] cell_en;

  // (base + offset) mod NREQ without a divider; offset never exceeds NREQ-1.
  function automatic logic [PTRW-1:0] rr_index(input logic [PTRW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return PTRW'(sum);
  endfunction

  // A requester is masked during its own grant cycle, which gives it time to
  // drop req or present a fresh command before it can win again.
  always_comb begin
    elig = req & ~gnt;
  end

  // Round-robin winner search starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && elig[rr_index(ptr, i)]) begin
        win_found = 1'b1;
        win       = rr_index(ptr, i);
      end
    end
  end

  // Route the winner's command fields to the shared cell control.
  always_comb begin
    win_op  = '0;
    win_idx = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (win == PTRW'(r)) begin
        win_op  = op[2*r +: 2];
        win_idx = idx[IDXW*r +: IDXW];
      end
    end
  end

  // Only the addressed cell is enabled; an out-of-range index matches no cell,
  // so such a command is still granted and counted but leaves q untouched.
  always_comb begin
    cell_en = '0;
    for (int b = 0; b < NBITS; b++) begin
      cell_en[b] = win_found && (int'(win_idx) == b);
    end
  end

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en[b]),
      .j   (win_op[1]),
      .k   (win_op[0]),
      .q   (q[b])
    );
  end

  // Grant, pointer and counter advance together on an executed command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      gnt     <= '0;
      cmd_cnt <= '0;
    end else if (win_found) begin
      gnt     <= NREQ'(1) << win;
      ptr     <= rr_index(win, 1);
      cmd_cnt <= cmd_cnt + CNT_W'(1);
    end else begin
      gnt     <= '0;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_jk_bank_arbiter
//   Directed bench for jk_bank_arbiter: an 8-bit bank and a 6-bit bank (for
//   out-of-range indices) share clock and reset.
// ----------------------------------------------------------------------------
module tb_jk_bank_arbiter;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  logic        clk;
  logic        rst;

  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [15:0] cmd_cnt;

  logic [3:0]  req6;
  logic [7:0]  op6;
  logic [11:0] idx6;
  logic [3:0]  gnt6;
  logic [5:0]  q6;
  logic [15:0] cmd_cnt6;

  int checkCount;
  int failCount;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .idx     (idx),
    .gnt     (gnt),
    .q       (q),
    .cmd_cnt (cmd_cnt)
  );

  jk_bank_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut6 (
    .clk     (clk),
    .rst     (rst),
    .req     (req6),
    .op      (op6),
    .idx     (idx6),
    .gnt     (gnt6),
    .q       (q6),
    .cmd_cnt (cmd_cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command on requester r of the 8-bit bank.
  task automatic applyStimulus(input int r, input logic [1:0] o, input logic [2:0] ix);
    op[2*r +: 2]  = o;
    idx[3*r +: 3] = ix;
    req[r]        = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checkCount++;
    if (got !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single command from requester r, then drop req in its grant cycle.
  task automatic singleCmd(input int r, input logic [1:0] o, input logic [2:0] ix);
    applyStimulus(r, o, ix);
    tick();
    req[r] = 1'b0;
    tick();
  endtask

  localparam int WRAP_RUN = 65533;

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst  = 1'b1;
    req  = '0;  op  = '0;  idx  = '0;
    req6 = '0;  op6 = '0;  idx6 = '0;

    // Reset state while rst is held.
    #3;
    checkOutput("reset_q",   32'(q),       32'h00);
    checkOutput("reset_gnt", 32'(gnt),     32'h0);
    checkOutput("reset_cnt", 32'(cmd_cnt), 32'h0);
    tick();
    rst = 1'b0;

    // Single set of bit 3 by requester 0.
    applyStimulus(0, OP_SET, 3'd3);
    tick();
    checkOutput("set3_q",   32'(q),       32'h08);
    checkOutput("set3_gnt", 32'(gnt),     32'h1);
    checkOutput("set3_cnt", 32'(cmd_cnt), 32'd1);
    req[0] = 1'b0;
    tick();
    checkOutput("set3_gnt_drop", 32'(gnt), 32'h0);

    // Build q = A5 from requester 0.
    singleCmd(0, OP_SET, 3'd0);
    singleCmd(0, OP_RST, 3'd3);
    singleCmd(0, OP_SET, 3'd2);
    singleCmd(0, OP_SET, 3'd5);
    singleCmd(0, OP_SET, 3'd7);
    checkOutput("build_a5_q",   32'(q),       32'hA5);
    checkOutput("build_a5_cnt", 32'(cmd_cnt), 32'd6);

    // Async reset in a grant cycle with a new command pending.
    applyStimulus(1, OP_SET, 3'd1);
    tick();
    checkOutput("pre_rst_gnt", 32'(gnt),     32'h2);
    checkOutput("pre_rst_q",   32'(q),       32'hA7);
    checkOutput("pre_rst_cnt", 32'(cmd_cnt), 32'd7);
    applyStimulus(1, OP_SET, 3'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_q",   32'(q),       32'h00);
    checkOutput("async_rst_gnt", 32'(gnt),     32'h0);
    checkOutput("async_rst_cnt", 32'(cmd_cnt), 32'h0);
    tick();
    checkOutput("rst_discard_q", 32'(q), 32'h00);

    // All four request at reset release; rotation starts at requester 0.
    req = '0;
    applyStimulus(0, OP_SET, 3'd0);
    applyStimulus(1, OP_SET, 3'd1);
    applyStimulus(2, OP_SET, 3'd2);
    applyStimulus(3, OP_SET, 3'd3);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << i));
      req[i] = 1'b0;
    end
    checkOutput("rr_q",   32'(q),       32'h0F);
    checkOutput("rr_cnt", 32'(cmd_cnt), 32'd4);
    tick();
    checkOutput("rr_idle_gnt", 32'(gnt), 32'h0);

    // Pointer has wrapped back to requester 0.
    for (int r = 0; r < 4; r++) applyStimulus(r, OP_HOLD, 3'd0);
    tick();
    checkOutput("ptr_wrap_gnt", 32'(gnt), 32'h1);
    checkOutput("hold_q",       32'(q),   32'h0F);
    req = '0;
    tick();

    // Same bit from two requesters: set (req2) then toggle (req3).
    applyStimulus(2, OP_SET, 3'd6);
    applyStimulus(3, OP_TGL, 3'd6);
    tick();
    checkOutput("same_bit_gnt_a", 32'(gnt), 32'h4);
    checkOutput("same_bit_q_a",   32'(q),   32'h4F);
    req[2] = 1'b0;
    tick();
    checkOutput("same_bit_gnt_b", 32'(gnt), 32'h8);
    checkOutput("same_bit_q_b",   32'(q),   32'h0F);
    checkOutput("same_bit_cnt",   32'(cmd_cnt), 32'd7);
    req[3] = 1'b0;
    tick();

    // Requester 1 toggles bit 5 twice; the masked cycle separates the grants.
    applyReset();
    applyStimulus(1, OP_TGL, 3'd5);
    tick();
    checkOutput("tgl1_gnt", 32'(gnt), 32'h2);
    checkOutput("tgl1_q",   32'(q),   32'h20);
    tick();
    checkOutput("tgl_mask_gnt", 32'(gnt), 32'h0);
    checkOutput("tgl_mask_q",   32'(q),   32'h20);
    tick();
    checkOutput("tgl2_gnt", 32'(gnt), 32'h2);
    checkOutput("tgl2_q",   32'(q),   32'h00);
    req[1] = 1'b0;
    tick();
    checkOutput("tgl_idle_gnt", 32'(gnt),     32'h0);
    checkOutput("tgl_cnt",      32'(cmd_cnt), 32'd2);

    // 6-bit bank: out-of-range index and hold are granted and counted only.
    req6         = 4'b0100;
    op6[5:4]     = OP_SET;
    idx6[8:6]    = 3'd2;
    tick();
    checkOutput("b6_pre_gnt", 32'(gnt6), 32'h4);
    checkOutput("b6_pre_q",   32'(q6),   32'h04);
    req6 = '0;
    tick();
    op6[1:0]  = OP_SET;
    idx6[2:0] = 3'd7;
    op6[3:2]  = OP_HOLD;
    idx6[5:3] = 3'd2;
    req6      = 4'b0011;
    tick();
    checkOutput("b6_oor_gnt", 32'(gnt6), 32'h1);
    checkOutput("b6_oor_q",   32'(q6),   32'h04);
    req6[0] = 1'b0;
    tick();
    checkOutput("b6_hold_gnt", 32'(gnt6),     32'h2);
    checkOutput("b6_hold_q",   32'(q6),       32'h04);
    checkOutput("b6_cnt",      32'(cmd_cnt6), 32'd3);
    req6 = '0;
    tick();

    // Counter wrap: run holds until 0xFFFF, then one real command.
    for (int r = 0; r < 4; r++) applyStimulus(r, OP_HOLD, 3'd0);
    repeat (WRAP_RUN) tick();
    req = '0;
    checkOutput("wrap_pre_cnt", 32'(cmd_cnt), 32'hFFFF);
    checkOutput("wrap_pre_q",   32'(q),       32'h00);
    tick();
    applyStimulus(2, OP_SET, 3'd6);
    tick();
    checkOutput("wrap_cnt", 32'(cmd_cnt), 32'h0000);
    checkOutput("wrap_q",   32'(q),       32'h40);
    checkOutput("wrap_gnt", 32'(gnt),     32'h4);
    req = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
